wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources:
  - the in-order pipeline writeback stage;
  - a variable-latency mul/div unit returning results out of band.
- Pipeline writes have priority. Mul/div results are buffered in a small FIFO and drained into idle write-port cycles.
- A starvation guard stalls the pipeline writeback when buffered results wait too long.
- Program-order WAW correctness is kept by squashing a buffered result when the pipeline writes the same register.

Parameters:
- DEPTH, 2, mul/div result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, cycles a non-empty FIFO waits before forcing a drain
- AW, 5, register address width
- DW, 64, data width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- pipe_valid  in  1  writeback stage holds a real instruction (not nop)
- pipe_regwrite  in  1  instruction writes a register
- pipe_wa  in  AW  destination register
- pipe_wd  in  DW  writeback value
- pipe_stall  out  1  writeback not consumed this cycle; upstream holds it
- md_valid  in  1  mul/div result offered
- md_wa  in  AW  mul/div destination
- md_wd  in  DW  mul/div result
- md_ready  out  1  arbiter accepts md result this cycle
- rf_we  out  1  register-file write enable
- rf_wa  out  AW  register-file write address
- rf_wd  out  DW  register-file write data
- fifo_count  out  $clog2(DEPTH)+1  occupied entries (debug/perf)

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset state:
  - FIFO empty, all kill bits 0, starve counter 0.
  - While reset is high: rf_we=0, md_ready=0, pipe_stall=0, fifo_count=0.
- Outputs are combinational from current inputs and registered state. State updates on rising clk.
- Definitions:
  - pw = pipe_valid & pipe_regwrite & (pipe_wa≠0). Writes to x0 are never issued.
  - Head entries with the kill bit set are popped without writing.
- force = (starve counter ≥ STARVE_LIMIT) & FIFO non-empty & head not killed.
- Port selection, in priority order:
  - force: write FIFO head; pipe_stall=pw; pop head; starve counter → 0.
  - pw: write pipeline value; pipe_stall=0.
  - FIFO non-empty: write head if not killed, else drop it; pop head.
  - FIFO empty & md_valid & md_wa≠0: bypass, write md value directly, nothing enqueued.
  - Otherwise rf_we=0.
- md_ready:
  - Asserted when FIFO not full, or when a pop occurs this cycle (simultaneous pop+push at full is allowed).
  - md accept with md_wa=0 is consumed and discarded.
  - An accepted md result that was not bypassed is enqueued at the tail.
- WAW squash:
  - When the pipeline write is committed (pw & !pipe_stall), every valid FIFO entry with wa==pipe_wa sets its kill bit.
  - An md result enqueued in that same cycle to the same wa is also killed. The pipeline instruction is younger.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, each cycle the FIFO is non-empty and no pop occurs.
  - Clears to 0 on pop or when the FIFO is empty.
- fifo_count reflects registered occupancy.
- Full FIFO with no drain: md_ready=0; md unit holds its result.
- Reset mid-operation: buffered results are discarded. The pipeline flush on reset covers correctness.

Decomposition:
- Shared package pipes:
  - typedef wb_req_t {valid, regwrite, wa, wd};
  - typedef md_result_t {wa, wd};
  - constant for STARVE_LIMIT default.
  - creg_addr_t / word_t from common.
- One sub-module, wb_result_fifo: DEPTH-entry circular buffer with per-entry kill bits and a tag-match kill port.
- Arbitration and the starve counter live in the top module.

Test Plan:
- Idle pipe, FIFO empty, md_valid with wa=5, wd=0x2A → same cycle rf_we=1, rf_wa=5, rf_wd=0x2A; fifo_count stays 0.
- pw on x3 every cycle; md offers x7 = 0x11 → md enqueued; rf writes x3. After 4 waiting cycles, force: rf writes x7 = 0x11, pipe_stall=1 for one cycle, counter clears.
- FIFO holds x9 = 0x55; pipeline commits x9 = 0x66 → entry killed; next idle cycle pops it with rf_we=0; regfile ends at 0x66.
- Fill FIFO (2 entries) under continuous pw with no force reached → md_ready=0. First pop cycle → md_ready=1, push and pop occur together, count stays 2.
- md result to x0 and pipeline write to x0 → rf_we=0, md_ready=1, nothing enqueued.
- Assert reset with 2 entries buffered → next cycle fifo_count=0, rf_we=0, md_ready=0 while reset is high.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_pkg
// Description : Shared types and default constants for the register-file
//               write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_port_arbiter_pkg;

    localparam int C_AW                   = 5;
    localparam int C_DW                   = 64;
    localparam int C_DEPTH_DEFAULT        = 2;
    localparam int C_STARVE_LIMIT_DEFAULT = 4;

    typedef logic [C_AW-1:0] creg_addr_t;
    typedef logic [C_DW-1:0] word_t;

    // Writeback-stage request as seen by the arbiter
    typedef struct packed {
        logic       valid;
        logic       regwrite;
        creg_addr_t wa;
        word_t      wd;
    } wb_req_t;

    // Out-of-band mul/div result
    typedef struct packed {
        creg_addr_t wa;
        word_t      wd;
    } md_result_t;

endpackage
`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_if
// Description : Bundle of the pipeline writeback, mul/div result and
//               register-file write-port signals around the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_port_arbiter_if
    import wb_port_arbiter_pkg::*;
#(
    parameter int AW    = C_AW,
    parameter int DW    = C_DW,
    parameter int DEPTH = C_DEPTH_DEFAULT
) ();

    localparam int CW = $clog2(DEPTH) + 1;

    logic          pipe_valid;
    logic          pipe_regwrite;
    logic [AW-1:0] pipe_wa;
    logic [DW-1:0] pipe_wd;
    logic          pipe_stall;

    logic          md_valid;
    logic [AW-1:0] md_wa;
    logic [DW-1:0] md_wd;
    logic          md_ready;

    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;

    logic [CW-1:0] fifo_count;

    // Sources (pipeline, mul/div unit) and register-file observer side
    modport master (
        output pipe_valid, pipe_regwrite, pipe_wa, pipe_wd,
        output md_valid, md_wa, md_wd,
        input  pipe_stall, md_ready, rf_we, rf_wa, rf_wd, fifo_count
    );

    // Arbiter side
    modport slave (
        input  pipe_valid, pipe_regwrite, pipe_wa, pipe_wd,
        input  md_valid, md_wa, md_wd,
        output pipe_stall, md_ready, rf_we, rf_wa, rf_wd, fifo_count
    );

endinterface
`default_nettype wire

// File: rtl/wb_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_result_fifo
// Description : Circular buffer of mul/div results with a kill bit per entry.
//               A tag-match port marks every matching entry as killed so a
//               stale result is dropped instead of written back.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int   DEPTH = C_DEPTH_DEFAULT,
    parameter int   AW    = C_AW,
    parameter int   DW    = C_DW,
    localparam int  CW    = $clog2(DEPTH) + 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_push,
    input  wire logic [AW-1:0] i_push_wa,
    input  wire logic [DW-1:0] i_push_wd,
    input  wire logic          i_push_kill,
    input  wire logic          i_pop,
    input  wire logic          i_kill_en,
    input  wire logic [AW-1:0] i_kill_wa,
    output logic               o_empty,
    output logic               o_full,
    output logic [AW-1:0]      o_head_wa,
    output logic [DW-1:0]      o_head_wd,
    output logic               o_head_kill,
    output logic [CW-1:0]      o_count
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]    r_wa [DEPTH];
    logic [DW-1:0]    r_wd [DEPTH];
    logic [DEPTH-1:0] r_kill;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Payload storage; written only at the tail on push
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_wa[r_wr_ptr] <= i_push_wa;
            r_wd[r_wr_ptr] <= i_push_wd;
        end
    end

    // Kill bits: a push installs a fresh bit; otherwise a tag match sets it.
    // Free slots may pick up a stale kill, but every push rewrites its bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_kill <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_push && (r_wr_ptr == PW'(i))) begin
                    r_kill[i] <= i_push_kill;
                end else if (i_kill_en && (r_wa[i] == i_kill_wa)) begin
                    r_kill[i] <= 1'b1;
                end
            end
        end
    end

    // Pointers and occupancy; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == CW'(DEPTH));
    assign o_head_wa   = r_wa[r_rd_ptr];
    assign o_head_wd   = r_wd[r_rd_ptr];
    assign o_head_kill = r_kill[r_rd_ptr];
    assign o_count     = r_count;

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the register-file write port between the in-order
//               writeback stage (priority) and buffered mul/div results,
//               with a starvation guard and WAW squash of buffered results.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH        = C_DEPTH_DEFAULT,
    parameter int STARVE_LIMIT = C_STARVE_LIMIT_DEFAULT,
    parameter int AW           = C_AW,
    parameter int DW           = C_DW
) (
    input  wire logic         clk,
    input  wire logic         reset,
    wb_port_arbiter_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic          w_pw;
    logic          w_empty;
    logic          w_full;
    logic [AW-1:0] w_head_wa;
    logic [DW-1:0] w_head_wd;
    logic          w_head_kill;
    logic [CW-1:0] w_count;
    logic          w_force;
    logic          w_pop;
    logic          w_bypass;
    logic          w_stall;
    logic          w_rf_we;
    logic [AW-1:0] w_rf_wa;
    logic [DW-1:0] w_rf_wd;
    logic          w_md_ready;
    logic          w_push;
    logic          w_commit;
    logic          w_push_kill;
    logic [SW-1:0] r_starve;

    // Write-port selection: forced drain, pipeline, buffered drain, bypass
    always_comb begin
        w_pw     = bus.pipe_valid & bus.pipe_regwrite & (bus.pipe_wa != '0);
        w_force  = (r_starve >= SW'(STARVE_LIMIT)) & ~w_empty & ~w_head_kill;
        w_rf_we  = 1'b0;
        w_rf_wa  = '0;
        w_rf_wd  = '0;
        w_stall  = 1'b0;
        w_pop    = 1'b0;
        w_bypass = 1'b0;
        if (!reset) begin
            if (w_force) begin
                w_rf_we = 1'b1;
                w_rf_wa = w_head_wa;
                w_rf_wd = w_head_wd;
                w_stall = w_pw;
                w_pop   = 1'b1;
            end else if (w_pw) begin
                w_rf_we = 1'b1;
                w_rf_wa = bus.pipe_wa;
                w_rf_wd = bus.pipe_wd;
            end else if (!w_empty) begin
                // A killed head is discarded without touching the regfile
                w_rf_we = ~w_head_kill;
                w_rf_wa = w_head_wa;
                w_rf_wd = w_head_wd;
                w_pop   = 1'b1;
            end else if (bus.md_valid && (bus.md_wa != '0)) begin
                w_rf_we  = 1'b1;
                w_rf_wa  = bus.md_wa;
                w_rf_wd  = bus.md_wd;
                w_bypass = 1'b1;
            end
        end
        // A pop frees a slot in the same cycle, so full+pop still accepts
        w_md_ready  = ~reset & (~w_full | w_pop);
        w_commit    = ~reset & w_pw & ~w_stall;
        // x0 results are accepted and dropped; bypassed ones never queue
        w_push      = bus.md_valid & w_md_ready & (bus.md_wa != '0) & ~w_bypass;
        // The pipeline instruction is younger than any mul/div result
        w_push_kill = w_commit & (bus.md_wa == bus.pipe_wa);
    end

    // Starvation counter: counts idle-waiting cycles of a non-empty buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve <= '0;
        end else if (w_pop || w_empty) begin
            r_starve <= '0;
        end else if (r_starve < SW'(STARVE_LIMIT)) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    wb_result_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_push),
        .i_push_wa   (bus.md_wa),
        .i_push_wd   (bus.md_wd),
        .i_push_kill (w_push_kill),
        .i_pop       (w_pop),
        .i_kill_en   (w_commit),
        .i_kill_wa   (bus.pipe_wa),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_head_wa   (w_head_wa),
        .o_head_wd   (w_head_wd),
        .o_head_kill (w_head_kill),
        .o_count     (w_count)
    );

    assign bus.rf_we      = w_rf_we;
    assign bus.rf_wa      = w_rf_wa;
    assign bus.rf_wd      = w_rf_wd;
    assign bus.pipe_stall = w_stall;
    assign bus.md_ready   = w_md_ready;
    assign bus.fifo_count = reset ? '0 : w_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Scoreboard bench for wb_port_arbiter: a behavioural model
//               predicts each cycle's outputs, directed scenarios add fixed
//               expectations, and a random phase exercises interleavings.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;
    localparam int AW    = 5;
    localparam int DW    = 64;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    wb_port_arbiter_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();

    wb_port_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT),
        .AW           (AW),
        .DW           (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        md_result_t r;
        bit         kill;
    } ent_t;

    typedef struct {
        bit         we;
        creg_addr_t wa;
        word_t      wd;
        bit         stall;
        bit         ready;
        int         count;
    } exp_t;

    ent_t  m_q[$];
    ent_t  n_q[$];
    int    m_starve;
    int    n_starve;
    exp_t  sb[$];
    word_t rf_model [32];
    int    n_vec = 0;
    int    n_err = 0;

    logic          o_we;
    logic          o_stall;
    logic          o_ready;
    logic [AW-1:0] o_wa;
    logic [DW-1:0] o_wd;
    int            o_count;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic drive(input bit pv, input bit prw, input int pwa, input logic [63:0] pwd,
                         input bit mv, input int mwa, input logic [63:0] mwd);
        bus.pipe_valid    = pv;
        bus.pipe_regwrite = prw;
        bus.pipe_wa       = AW'(pwa);
        bus.pipe_wd       = pwd;
        bus.md_valid      = mv;
        bus.md_wa         = AW'(mwa);
        bus.md_wd         = mwd;
    endtask

    // Behavioural prediction for the current cycle plus next model state
    task automatic model_eval();
        exp_t e;
        ent_t en;
        bit   pw, empty, frc, pop, byp, commit;
        e.we = 0; e.wa = '0; e.wd = '0; e.stall = 0; e.ready = 0; e.count = 0;
        n_q = m_q;
        n_starve = m_starve;
        if (reset) begin
            n_q.delete();
            n_starve = 0;
        end else begin
            pw    = bus.pipe_valid && bus.pipe_regwrite && (bus.pipe_wa != 0);
            empty = (m_q.size() == 0);
            frc   = !empty && (m_starve >= LIMIT) && !m_q[0].kill;
            pop   = 0;
            byp   = 0;
            if (frc) begin
                e.we = 1; e.wa = m_q[0].r.wa; e.wd = m_q[0].r.wd; e.stall = pw; pop = 1;
            end else if (pw) begin
                e.we = 1; e.wa = bus.pipe_wa; e.wd = bus.pipe_wd;
            end else if (!empty) begin
                e.we = !m_q[0].kill; e.wa = m_q[0].r.wa; e.wd = m_q[0].r.wd; pop = 1;
            end else if (bus.md_valid && (bus.md_wa != 0)) begin
                e.we = 1; e.wa = bus.md_wa; e.wd = bus.md_wd; byp = 1;
            end
            e.ready = (m_q.size() < DEPTH) || pop;
            e.count = m_q.size();
            commit  = pw && !e.stall;
            if (pop) void'(n_q.pop_front());
            if (commit) begin
                foreach (n_q[k]) if (n_q[k].r.wa == bus.pipe_wa) n_q[k].kill = 1;
            end
            if (bus.md_valid && e.ready && (bus.md_wa != 0) && !byp) begin
                en.r.wa = bus.md_wa;
                en.r.wd = bus.md_wd;
                en.kill = commit && (bus.md_wa == bus.pipe_wa);
                n_q.push_back(en);
            end
            if (pop || empty)       n_starve = 0;
            else if (m_starve < LIMIT) n_starve = m_starve + 1;
            else                    n_starve = LIMIT;
        end
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check_eq("rf_we", o_we, e.we);
            if (e.we) begin
                check_eq("rf_wa", o_wa, e.wa);
                check_eq("rf_wd", o_wd, e.wd);
            end
            check_eq("pipe_stall", o_stall, e.stall);
            check_eq("md_ready", o_ready, e.ready);
            check_eq("fifo_count", o_count, e.count);
        end
    endtask

    // One clock: sample just after inputs settle, check, then advance
    task automatic step();
        #1;
        o_we    = bus.rf_we;
        o_wa    = bus.rf_wa;
        o_wd    = bus.rf_wd;
        o_stall = bus.pipe_stall;
        o_ready = bus.md_ready;
        o_count = int'(bus.fifo_count);
        model_eval();
        compare_out();
        @(posedge clk);
        if (o_we) rf_model[o_wa] = o_wd;
        m_q = n_q;
        m_starve = n_starve;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         mv;
        int         mwa;
        logic [63:0] mwd;
        m_starve = 0;
        foreach (rf_model[i]) rf_model[i] = '0;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        step();
        step();
        check_eq("rst_count", o_count, 0);
        check_eq("rst_we", o_we, 0);
        reset = 1'b0;

        // Bypass into an idle port
        drive(0, 0, 0, 0, 1, 5, 64'h2A);
        step();
        check_eq("byp_we", o_we, 1);
        check_eq("byp_wa", o_wa, 5);
        check_eq("byp_wd", o_wd, 64'h2A);
        check_eq("byp_count", o_count, 0);

        // Starvation forces a drain while the pipeline writes x3 every cycle
        drive(1, 1, 3, 64'h100, 1, 7, 64'h11);
        step();
        check_eq("starve_first_wa", o_wa, 3);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 3, 64'h101 + 64'(i), 0, 0, 0);
            step();
            check_eq("starve_wait_stall", o_stall, 0);
        end
        step();
        check_eq("force_wa", o_wa, 7);
        check_eq("force_wd", o_wd, 64'h11);
        check_eq("force_stall", o_stall, 1);
        step();
        check_eq("after_force_stall", o_stall, 0);
        check_eq("after_force_wa", o_wa, 3);

        // WAW squash: buffered x9 killed by a younger pipeline write
        drive(1, 1, 3, 64'h200, 1, 9, 64'h55);
        step();
        drive(1, 1, 9, 64'h66, 0, 0, 0);
        step();
        check_eq("waw_pipe_wd", o_wd, 64'h66);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        check_eq("waw_drop_we", o_we, 0);
        check_eq("waw_drop_count", o_count, 1);
        step();
        check_eq("waw_empty_count", o_count, 0);
        check_eq("waw_x9_value", rf_model[9], 64'h66);

        // Fill to full under continuous pw, then pop+push together
        drive(1, 1, 3, 64'h300, 1, 10, 64'hA0);
        step();
        drive(1, 1, 3, 64'h301, 1, 11, 64'hB0);
        step();
        drive(1, 1, 3, 64'h302, 1, 12, 64'hC0);
        step();
        check_eq("full_ready", o_ready, 0);
        check_eq("full_count", o_count, 2);
        drive(0, 0, 0, 0, 1, 12, 64'hC0);
        step();
        check_eq("popfull_ready", o_ready, 1);
        check_eq("popfull_wa", o_wa, 10);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        check_eq("popfull_count", o_count, 2);
        step();
        step();
        check_eq("drained_count", o_count, 0);

        // x0 from both sources
        drive(1, 1, 0, 64'hDEAD, 1, 0, 64'hBEEF);
        step();
        check_eq("x0_we", o_we, 0);
        check_eq("x0_ready", o_ready, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        check_eq("x0_count", o_count, 0);

        // Reset with two buffered results
        drive(1, 1, 3, 64'h400, 1, 13, 64'hD0);
        step();
        drive(1, 1, 3, 64'h401, 1, 14, 64'hE0);
        step();
        reset = 1'b1;
        step();
        check_eq("rstmid_we", o_we, 0);
        check_eq("rstmid_ready", o_ready, 0);
        check_eq("rstmid_count", o_count, 0);
        step();
        check_eq("rstmid_count2", o_count, 0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        check_eq("rstmid_after_we", o_we, 0);
        check_eq("rstmid_after_count", o_count, 0);

        // Random interleavings; the mul/div unit holds until accepted
        mv  = 0;
        mwa = 0;
        mwd = '0;
        for (int c = 0; c < 400; c++) begin
            if (!mv && ($urandom_range(0, 2) != 0)) begin
                mv  = 1;
                mwa = $urandom_range(0, 3);
                mwd = {$urandom, $urandom};
            end
            reset = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                  {$urandom, $urandom}, mv, mwa, mwd);
            step();
            if (mv && o_ready) mv = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
